// File: rtl/iface_bus_arbiter.sv
// Round-robin arbiter sharing one DW-bit bus between NREQ requesters.
// Optional burst mode (grant held until last/MAX_BURST) is enabled by IFACE_ARB_BURST_EN.
module iface_bus_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               last,
    input  logic [NREQ*DW-1:0]            wdata,
    output logic [NREQ-1:0]               gnt,
    output logic [$clog2(NREQ)-1:0]       owner,
    output logic [DW-1:0]                 bus_data,
    output logic                          bus_valid,
    input  logic                          bus_ready,
    output logic                          busy
);

    localparam int unsigned OW = $clog2(NREQ);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [OW-1:0]       owner_q, owner_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic [OW-1:0]       rr_ptr_q, rr_ptr_d;

`ifdef IFACE_ARB_BURST_EN
    localparam int unsigned CW = $clog2(MAX_BURST + 1);
    logic [CW-1:0]       cnt_q, cnt_d;
`else
    logic                unused_last;
    assign unused_last = ^last;
`endif

    // First requester at or after ptr, wrapping modulo NREQ.
    function automatic logic [OW-1:0] pick_f(input logic [NREQ-1:0] mask,
                                             input logic [OW-1:0]   ptr);
        logic [OW-1:0] sel;
        logic          found;
        int unsigned   idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && mask[OW'(idx)]) begin
                sel   = OW'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [NREQ-1:0] onehot_f(input logic [OW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

    function automatic logic [OW-1:0] next_idx_f(input logic [OW-1:0] idx);
        return (idx == OW'(NREQ - 1)) ? '0 : OW'(idx + 1'b1);
    endfunction

    logic            beat;
    logic            rel;
    logic [OW-1:0]   sel;
    logic [OW-1:0]   ptr_nxt;
    logic [NREQ-1:0] mask;

    // Next-state, grant handover and bus mux.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gnt_d     = gnt_q;
        rr_ptr_d  = rr_ptr_q;
`ifdef IFACE_ARB_BURST_EN
        cnt_d     = cnt_q;
`endif
        bus_valid = 1'b0;
        bus_data  = '0;
        beat      = 1'b0;
        rel       = 1'b0;
        sel       = '0;
        ptr_nxt   = next_idx_f(owner_q);
        mask      = req & ~onehot_f(owner_q);

        case (state_q)
            IDLE: begin
                if (|req) begin
                    sel     = pick_f(req, rr_ptr_q);
                    state_d = XFER;
                    owner_d = sel;
                    gnt_d   = onehot_f(sel);
                end
            end
            XFER: begin
                bus_valid = req[owner_q];
                bus_data  = wdata[32'(owner_q)*DW +: DW];
                beat      = bus_valid & bus_ready;
`ifdef IFACE_ARB_BURST_EN
                rel       = beat & (last[owner_q] | (cnt_q == CW'(MAX_BURST - 1)));
`else
                rel       = beat;
`endif
                // A withdrawn owner is retired exactly like a release, minus the beat.
                if (rel || !req[owner_q]) begin
                    rr_ptr_d = ptr_nxt;
`ifdef IFACE_ARB_BURST_EN
                    cnt_d    = '0;
`endif
                    if (|mask) begin
                        sel     = pick_f(mask, ptr_nxt);
                        owner_d = sel;
                        gnt_d   = onehot_f(sel);
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
`ifdef IFACE_ARB_BURST_EN
                else if (beat) begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            gnt_q    <= '0;
            rr_ptr_q <= '0;
`ifdef IFACE_ARB_BURST_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            rr_ptr_q <= rr_ptr_d;
`ifdef IFACE_ARB_BURST_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = (state_q == XFER);

endmodule

// File: tb/tb_iface_bus_arbiter.sv
// Randomized and directed bench for iface_bus_arbiter against a transaction-level model.
// Burst scenarios run when IFACE_ARB_BURST_EN is defined.
module tb_iface_bus_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;
`ifdef IFACE_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      last;
    logic [NREQ*DW-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic [1:0]           owner;
    logic [DW-1:0]        bus_data;
    logic                 bus_valid;
    logic                 bus_ready;
    logic                 busy;

    iface_bus_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .wdata     (wdata),
        .gnt       (gnt),
        .owner     (owner),
        .bus_data  (bus_data),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: who holds the bus, where the search resumes, beats in this grant.
    bit m_granted;
    int m_owner;
    int m_ptr;
    int m_beats;
    int dut_beats [NREQ];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find_req(input logic [NREQ-1:0] r, input int start);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(start + k) % NREQ]) return (start + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_granted = 1'b0;
        m_owner   = 0;
        m_ptr     = 0;
        m_beats   = 0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l, input logic rd);
        bit valid, beat, done;
        int nxt;
        logic [NREQ-1:0] others;
        if (!m_granted) begin
            nxt = find_req(r, m_ptr);
            if (nxt >= 0) begin
                m_granted = 1'b1;
                m_owner   = nxt;
            end
        end else begin
            valid = r[m_owner];
            beat  = valid && rd;
            if (beat) m_beats++;
            done = !valid || (beat && (!BURST || l[m_owner] || m_beats == MAXB));
            if (done) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_beats = 0;
                others  = r;
                others[m_owner] = 1'b0;
                nxt = find_req(others, m_ptr);
                if (nxt >= 0) m_owner = nxt;
                else          m_granted = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, compare outputs against the model, advance the model.
    task automatic drive_cycle(input logic [NREQ-1:0] r, input logic [NREQ-1:0] l,
                               input logic rd, input logic [NREQ*DW-1:0] wd);
        logic [NREQ-1:0] exp_gnt;
        @(negedge clk);
        req = r; last = l; bus_ready = rd; wdata = wd;
        #1;
        exp_gnt = m_granted ? (NREQ'(1) << m_owner) : '0;
        check("busy", 32'(busy), 32'(m_granted));
        check("gnt", 32'(gnt), 32'(exp_gnt));
        if (m_granted) check("owner", 32'(owner), 32'(m_owner));
        check("bus_valid", 32'(bus_valid), 32'(m_granted && r[m_owner]));
        check("bus_data", 32'(bus_data), m_granted ? 32'(wd[m_owner*DW +: DW]) : 32'd0);
        if (bus_valid && bus_ready) dut_beats[owner]++;
        model_step(r, l, rd);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        req   = '0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(bus_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(bus_data), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [NREQ*DW-1:0] rand_wd();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        logic [NREQ*DW-1:0] hold_wd;
        int saved;
        logic [NREQ-1:0] rl;
        for (int i = 0; i < NREQ; i++) dut_beats[i] = 0;
        rst_n = 1'b0; req = '0; last = '0; bus_ready = 1'b0; wdata = '0;
        model_reset();
        #22;
        check("reset_gnt", 32'(gnt), 32'd0);
        check("reset_owner", 32'(owner), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(bus_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request: grant after one cycle, one beat of A5, then release.
        drive_cycle(4'b0001, '0, 1'b1, 32'h000000A5);
        drive_cycle(4'b0001, '0, 1'b1, 32'h000000A5);
        check("single_gnt", 32'(gnt), 32'd1);
        check("single_data", 32'(bus_data), 32'hA5);
`ifndef IFACE_ARB_BURST_EN
        drive_cycle(4'b0000, '0, 1'b1, rand_wd());
        check("single_release", 32'(gnt), 32'd0);
`else
        drive_cycle(4'b0001, 4'b0001, 1'b1, 32'h000000A5);
        drive_cycle(4'b0000, '0, 1'b1, rand_wd());
        check("single_release", 32'(gnt), 32'd0);
`endif
        // Pointer now past requester 0.
        drive_cycle(4'b0011, '0, 1'b0, rand_wd());
        drive_cycle(4'b0011, '0, 1'b0, rand_wd());
        check("ptr_advanced", 32'(owner), 32'd1);
        drive_cycle(4'b0000, '0, 1'b0, rand_wd());

        // Stall with owner 2.
        hold_wd = rand_wd();
        drive_cycle(4'b0100, '0, 1'b0, hold_wd);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(4'b0110, '0, 1'b0, hold_wd);
            check("stall_owner", 32'(owner), 32'd2);
            check("stall_data", 32'(bus_data), 32'(hold_wd[2*DW +: DW]));
        end
        drive_cycle(4'b0110, 4'b0100, 1'b1, hold_wd);
        drive_cycle(4'b0010, '0, 1'b0, rand_wd());
        check("stall_handover", 32'(owner), 32'd1);

        // Owner 1 withdraws while 3 waits.
        saved = dut_beats[1];
        drive_cycle(4'b1000, '0, 1'b0, rand_wd());
        drive_cycle(4'b1000, '0, 1'b0, rand_wd());
        check("withdraw_gnt", 32'(gnt), 32'b1000);
        check("withdraw_beats", 32'(dut_beats[1]), 32'(saved));
        drive_cycle(4'b0000, '0, 1'b0, rand_wd());
        drive_cycle(4'b0000, '0, 1'b0, rand_wd());

`ifndef IFACE_ARB_BURST_EN
        // All requesting: one owner per cycle in rotation, one beat per cycle.
        drive_cycle(4'b1111, '0, 1'b1, rand_wd());
        for (int i = 0; i < 5; i++) begin
            drive_cycle(4'b1111, '0, 1'b1, rand_wd());
            check("rr_owner", 32'(owner), 32'(i % NREQ));
            check("rr_beat", 32'(bus_valid & bus_ready), 32'd1);
        end
        drive_cycle(4'b0000, '0, 1'b1, rand_wd());
`else
        // Requester 0 bursts to MAX_BURST; requester 1 ends its burst with last.
        reset_mid();
        drive_cycle(4'b0011, '0, 1'b1, rand_wd());
        for (int i = 0; i < MAXB; i++) begin
            drive_cycle(4'b0011, '0, 1'b1, rand_wd());
            check("burst_owner0", 32'(owner), 32'd0);
        end
        drive_cycle(4'b0011, '0, 1'b1, rand_wd());
        check("burst_owner1_b1", 32'(owner), 32'd1);
        drive_cycle(4'b0011, 4'b0010, 1'b1, rand_wd());
        check("burst_owner1_b2", 32'(owner), 32'd1);
        drive_cycle(4'b0011, '0, 1'b1, rand_wd());
        check("burst_last_release", 32'(owner), 32'd0);
`endif
        drive_cycle(4'b0000, '0, 1'b1, rand_wd());

        // Reset in the middle of a transfer; pointer restarts at 0.
        drive_cycle(4'b0001, '0, 1'b1, rand_wd());
        drive_cycle(4'b0001, '0, 1'b1, rand_wd());
        drive_cycle(4'b0011, '0, 1'b1, rand_wd());
        reset_mid();
        drive_cycle(4'b1010, '0, 1'b0, rand_wd());
        drive_cycle(4'b1010, '0, 1'b0, rand_wd());
        check("post_reset_owner", 32'(owner), 32'd1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            rl = NREQ'($urandom()) & NREQ'($urandom());
            drive_cycle(NREQ'($urandom()), rl, ($urandom_range(0, 3) != 0), rand_wd());
            if (c == 1500) reset_mid();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/iface_bus_arbiter.md
# iface_bus_arbiter

Round-robin arbiter that shares one 8-bit interface data bus between several requesters. It sits between the requesting modules and the single bus consumer. It grants one requester at a time, muxes that requester's data onto the bus, and releases the grant when the transfer handshake completes. An optional burst mode lets one owner keep the bus for several beats.

## Interface

Parameters:

- `NREQ`, 4, number of requesters (2..8)
- `DW`, 8, data width of each requester and of the bus
- `MAX_BURST`, 4, maximum beats per grant in burst mode (1..16); unused without the macro

Ports:

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input NREQ: per-requester request; held high until a beat completes or the requester withdraws.
- `last` input NREQ: per-requester end-of-burst flag; used only in burst mode.
- `wdata` input NREQ*DW: requester i's data in bits [i*DW +: DW].
- `gnt` output NREQ: one-hot grant, registered.
- `owner` output $clog2(NREQ): index of the current grant holder, registered.
- `bus_data` output DW: data of the granted requester.
- `bus_valid` output 1: beat valid on the bus.
- `bus_ready` input 1: consumer accepts the beat.
- `busy` output 1: high while any grant is held.

## Operation

State machine:

- Two states: IDLE and XFER.
- Pointer register `rr_ptr`, width $clog2(NREQ).

Reset (all values asynchronous):

- `gnt`=0, `owner`=0, `busy`=0, `bus_valid`=0, `bus_data`=0.
- `rr_ptr`=0, beat counter=0, state=IDLE.

Arbitration (`pick`):

- Selects the first index with `req` high, searching `rr_ptr`, `rr_ptr`+1, … modulo NREQ.

IDLE:

- If any `req` is high, go to XFER next edge, with `owner`=pick and `gnt`=one-hot(pick).
- Otherwise stay in IDLE.

XFER outputs (combinational from registered `owner`):

- `bus_valid` = `req[owner]`.
- `bus_data` = `wdata[owner]`.
- Outside XFER, `bus_valid`=0 and `bus_data`=0.

Beat:

- A beat is any cycle in XFER with `bus_valid` and `bus_ready` both high.

Release condition:

- Without the macro: every beat.
- With the macro: a beat with `last[owner]`=1, or the MAX_BURST-th beat of the grant.

Release action:

- Set `rr_ptr` = `owner`+1 modulo NREQ.
- Clear the beat counter.
- Re-arbitrate on the same edge, with the new pointer and the current `req` excluding the owner:
  - If a request is pending, stay in XFER with the new `owner`/`gnt`. There is no idle cycle.
  - Otherwise go to IDLE with `gnt`=0.

Withdrawal:

- If `req[owner]` drops in XFER before the release condition, the grant ends at that edge.
- It is handled like a release, except that no beat is counted.
- `rr_ptr` still advances past the withdrawn owner.

Starvation:

- No requester waits more than NREQ-1 grants.

## Timing

- Request-to-grant latency: `req` high before edge N gives `gnt` high after edge N (1 cycle).
- `bus_valid` follows `req[owner]` combinationally within the XFER cycle. No registering of data occurs; `bus_data` has zero latency from `wdata`.
- Grant handover:
  - Happens on the edge that completes the releasing beat.
  - The next owner's data is on the bus the following cycle.
  - Sustained throughput with two or more requesters is one beat per cycle.
- `bus_ready` low stalls indefinitely; `gnt`, `owner` and the beat counter hold.
- Asynchronous reset mid-transfer:
  - Outputs drop immediately.
  - No beat is counted for the cycle in which `rst_n` falls.
- `busy` = (state == XFER), registered together with the state.

## Configuration

Macro `IFACE_ARB_BURST_EN`:

- Defined:
  - Compiles in the beat counter, $clog2(MAX_BURST+1) bits.
  - Compiles in `last` handling.
  - The grant persists across beats until the burst release condition.
- Undefined:
  - No counter is synthesised.
  - `last` is ignored.
  - The grant is released after every single beat.

## Test plan

- Reset and single request:
  - Stimulus: `rst_n` low, then `req`=0001, `wdata[0]`=8'hA5, `bus_ready`=1.
  - Required: `gnt`=0001 one cycle after `req`; one beat of 8'hA5; `gnt`=0 next cycle; `rr_ptr`=1.
- Round-robin fairness:
  - Stimulus: `req`=1111 held, `bus_ready`=1, no macro.
  - Required: `owner` sequence 0,1,2,3,0 on consecutive cycles; one beat per cycle.
- Stall:
  - Stimulus: owner 2 granted, `bus_ready`=0 for 5 cycles.
  - Required: `gnt`, `owner` and `bus_data` stable; no handover; beat and release on the first ready cycle.
- Withdrawal:
  - Stimulus: owner 1 drops `req` with `bus_ready`=0 while `req[3]`=1.
  - Required: `gnt`=1000 next cycle; no beat counted for requester 1.
- Burst (macro defined, MAX_BURST=4):
  - Stimulus: `req`=0011, requester 0 never asserts `last`.
  - Required: 4 beats from owner 0, then `owner`=1.
  - Stimulus: requester 1 asserts `last` on beat 2.
  - Required: release after 2 beats.
- Reset mid-burst:
  - Stimulus: `rst_n` low during beat 3.
  - Required: `gnt`=0, `bus_valid`=0 immediately; after release, `req`=0010 grants owner 1 starting from `rr_ptr`=0.
